reveal_engine: RTL

REVEAL_ENGINE -- requirements
Module: reveal_engine

---
 rtl/reveal_engine_pkg.sv | 36 +++
 rtl/reveal_engine_neighbour_zero_check.sv | 38 +++
 rtl/reveal_engine.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/reveal_engine_pkg.sv
// Shared constants and encodings for the minesweeper reveal engine.
package reveal_engine_pkg;

  // Default board geometry
  localparam int unsigned BoardXSize = 16;
  localparam int unsigned BoardYSize = 16;
  localparam int unsigned BoardXBits = 4;
  localparam int unsigned BoardYBits = 4;

  // Cell value encoding: bit 4 marks a mine, otherwise bits 3:0 hold the neighbour count
  localparam int unsigned CellValBits = 5;
  localparam int unsigned MineBit     = 4;

  typedef enum logic [1:0] {
    GamePlaying = 2'b00,
    GameWon     = 2'b01,
    GameLost    = 2'b10
  } game_state_e;

  typedef enum logic [1:0] {
    DispHidden   = 2'b00,
    DispFlagged  = 2'b01,
    DispRevealed = 2'b10
  } disp_state_e;

  // C* states serve a player click, S* states serve the flood-fill sweep
  typedef enum logic [2:0] {
    StIdle,
    StCRead,
    StCWait,
    StScan,
    StSRead,
    StSWait
  } fsm_state_e;

endpackage

// File: rtl/reveal_engine_neighbour_zero_check.sv
// Combinational test: does any in-bounds 8-neighbour of (x, y) hold a revealed zero?
module reveal_engine_neighbour_zero_check #(
  parameter int unsigned X_SIZE = 16,
  parameter int unsigned Y_SIZE = 16,
  parameter int unsigned X_BITS = 4,
  parameter int unsigned Y_BITS = 4
) (
  input  logic [X_SIZE*Y_SIZE-1:0] zero,
  input  logic [X_BITS-1:0]        x,
  input  logic [Y_BITS-1:0]        y,
  output logic                     any_zero
);

  localparam int unsigned IdxBits = $clog2(X_SIZE * Y_SIZE);

  // OR together the zero bits of the neighbours, skipping those that fall off the board
  always_comb begin
    int nx;
    int ny;
    logic [IdxBits-1:0] idx;
    any_zero = 1'b0;
    nx       = 0;
    ny       = 0;
    idx      = '0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx = int'(x) + dx;
        ny = int'(y) + dy;
        if (!(dx == 0 && dy == 0) && nx >= 0 && nx < int'(X_SIZE) &&
            ny >= 0 && ny < int'(Y_SIZE)) begin
          idx      = IdxBits'(ny * int'(X_SIZE) + nx);
          any_zero = any_zero | zero[idx];
        end
      end
    end
  end

endmodule

// File: rtl/reveal_engine.sv
// Reveal engine: accepts flag/reveal clicks, reads the board and flood-fills zero regions.
module reveal_engine
  import reveal_engine_pkg::*;
#(
  parameter int unsigned X_SIZE = BoardXSize,
  parameter int unsigned Y_SIZE = BoardYSize,
  parameter int unsigned X_BITS = BoardXBits,
  parameter int unsigned Y_BITS = BoardYBits
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     board_ready,
  input  logic                     click_valid,
  output logic                     click_ready,
  input  logic [X_BITS-1:0]        click_x,
  input  logic [Y_BITS-1:0]        click_y,
  input  logic                     click_flag,
  output logic [X_BITS-1:0]        rd_x,
  output logic [Y_BITS-1:0]        rd_y,
  input  logic [CellValBits-1:0]   rd_val,
  input  logic [X_BITS+Y_BITS:0]   num_non_mines,
  input  logic [X_BITS-1:0]        disp_x,
  input  logic [Y_BITS-1:0]        disp_y,
  output logic [1:0]               disp_state,
  output logic [X_BITS+Y_BITS:0]   revealed_count,
  output logic [1:0]               game_state,
  output logic                     busy
);

  localparam int unsigned NumCells = X_SIZE * Y_SIZE;
  localparam int unsigned IdxBits  = $clog2(NumCells);
  localparam int unsigned CntBits  = X_BITS + Y_BITS + 1;

  function automatic logic [IdxBits-1:0] cell_idx(input logic [X_BITS-1:0] x,
                                                  input logic [Y_BITS-1:0] y);
    return IdxBits'(int'(y) * int'(X_SIZE) + int'(x));
  endfunction

  logic [NumCells-1:0] revealed_q, flagged_q, zero_q;
  fsm_state_e          state_q;
  game_state_e         game_q;
  disp_state_e         disp_q;
  logic [CntBits-1:0]  count_q, count_inc;
  logic [X_BITS-1:0]   rd_x_q, scan_x_q, scan_next_x;
  logic [Y_BITS-1:0]   rd_y_q, scan_y_q, scan_next_y;
  logic                changed_q;
  logic [IdxBits-1:0]  click_idx, rd_idx, scan_idx, disp_idx;
  logic                scan_nb_zero, candidate, scan_last, safe, is_zero, accept;

  assign click_idx = cell_idx(click_x, click_y);
  assign rd_idx    = cell_idx(rd_x_q, rd_y_q);
  assign scan_idx  = cell_idx(scan_x_q, scan_y_q);
  assign disp_idx  = cell_idx(disp_x, disp_y);

  assign click_ready = (state_q == StIdle) && board_ready && (game_q == GamePlaying);
  assign accept      = click_valid && click_ready;
  assign count_inc   = count_q + CntBits'(1);
  assign safe        = !rd_val[MineBit];
  assign is_zero     = (rd_val == '0);

  reveal_engine_neighbour_zero_check #(
    .X_SIZE (X_SIZE),
    .Y_SIZE (Y_SIZE),
    .X_BITS (X_BITS),
    .Y_BITS (Y_BITS)
  ) u_nb_check (
    .zero     (zero_q),
    .x        (scan_x_q),
    .y        (scan_y_q),
    .any_zero (scan_nb_zero)
  );

  assign candidate = !revealed_q[scan_idx] && !flagged_q[scan_idx] && scan_nb_zero;
  assign scan_last = (scan_x_q == X_BITS'(X_SIZE - 1)) && (scan_y_q == Y_BITS'(Y_SIZE - 1));

  // Row-major successor of the current sweep position
  always_comb begin
    scan_next_x = scan_x_q + X_BITS'(1);
    scan_next_y = scan_y_q;
    if (scan_x_q == X_BITS'(X_SIZE - 1)) begin
      scan_next_x = '0;
      scan_next_y = scan_y_q + Y_BITS'(1);
    end
  end

  // Main FSM: click handling, cell evaluation and the repeating sweep
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      game_q     <= GamePlaying;
      revealed_q <= '0;
      flagged_q  <= '0;
      zero_q     <= '0;
      count_q    <= '0;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
      scan_x_q   <= '0;
      scan_y_q   <= '0;
      changed_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (click_flag) begin
              if (!revealed_q[click_idx]) flagged_q[click_idx] <= ~flagged_q[click_idx];
            end else if (!revealed_q[click_idx] && !flagged_q[click_idx]) begin
              rd_x_q  <= click_x;
              rd_y_q  <= click_y;
              state_q <= StCRead;
            end
          end
        end
        StCRead: state_q <= StCWait;
        StCWait: begin
          revealed_q[rd_idx] <= 1'b1;
          if (!safe) begin
            game_q  <= GameLost;
            state_q <= StIdle;
          end else begin
            count_q <= count_inc;
            if (count_inc == num_non_mines) game_q <= GameWon;
            if (is_zero) begin
              zero_q[rd_idx] <= 1'b1;
              scan_x_q       <= '0;
              scan_y_q       <= '0;
              changed_q      <= 1'b0;
              state_q        <= StScan;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StScan: begin
          if (candidate) begin
            rd_x_q  <= scan_x_q;
            rd_y_q  <= scan_y_q;
            state_q <= StSRead;
          end else if (!scan_last) begin
            scan_x_q <= scan_next_x;
            scan_y_q <= scan_next_y;
          end else if (changed_q) begin
            scan_x_q  <= '0;
            scan_y_q  <= '0;
            changed_q <= 1'b0;
          end else begin
            state_q <= StIdle;
          end
        end
        StSRead: state_q <= StSWait;
        StSWait: begin
          // A mine found by the sweep stays hidden and does not count as progress
          if (safe) begin
            revealed_q[rd_idx] <= 1'b1;
            count_q            <= count_inc;
            if (count_inc == num_non_mines) game_q <= GameWon;
            if (is_zero) zero_q[rd_idx] <= 1'b1;
          end
          if (!scan_last) begin
            scan_x_q <= scan_next_x;
            scan_y_q <= scan_next_y;
            state_q  <= StScan;
            if (safe) changed_q <= 1'b1;
          end else if (changed_q || safe) begin
            scan_x_q  <= '0;
            scan_y_q  <= '0;
            changed_q <= 1'b0;
            state_q   <= StScan;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Display lookup, one cycle behind the arrays; revealed wins over flagged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_q <= DispHidden;
    end else if (revealed_q[disp_idx]) begin
      disp_q <= DispRevealed;
    end else if (flagged_q[disp_idx]) begin
      disp_q <= DispFlagged;
    end else begin
      disp_q <= DispHidden;
    end
  end

  assign rd_x           = rd_x_q;
  assign rd_y           = rd_y_q;
  assign disp_state     = disp_q;
  assign revealed_count = count_q;
  assign game_state     = game_q;
  assign busy           = (state_q != StIdle);

endmodule
